// File: rtl/mips_bus_pkg.sv
// mips_bus_pkg: shared state encoding and bus constants for the Harvard-to-shared-bus bridge.
package mips_bus_pkg;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DATA, S_COMMIT, S_HALT} state_t;
    localparam logic [3:0]  BYTEENABLE_ALL = 4'b1111;
    localparam logic [31:0] WORD_MASK      = 32'hFFFF_FFFC;
endpackage

// File: rtl/mips_wait_counter.sv
// mips_wait_counter: counts consecutive stalled bus cycles and flags the cycle that reaches MAX_WAIT.
module mips_wait_counter #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic count_en_i,
    output logic limit_o
);
    localparam int W = $clog2(MAX_WAIT + 1);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk) begin
        if (reset || clear_i) cnt_q <= '0;
        else if (count_en_i)  cnt_q <= cnt_q + 1'b1;
    end
    // limit fires during the MAX_WAIT-th stalled cycle, so that cycle is the last one tolerated
    assign limit_o = count_en_i && (cnt_q == W'(MAX_WAIT - 1));
endmodule

// File: rtl/mips_harvard_bus_bridge.sv
// mips_harvard_bus_bridge: serialises CPU instruction fetches and data accesses onto one shared bus,
// stalling the CPU with a one-cycle advance strobe and halting on a bus timeout.
module mips_harvard_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] bus_address,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] bus_writedata,
    output logic [3:0]  bus_byteenable,
    input  logic        bus_waitrequest,
    input  logic [31:0] bus_readdata,
    output logic        bus_error
);
    state_t      state_q, state_d;
    logic        decode_q, decode_d;
    logic [31:0] instr_q, instr_d, dread_q, dread_d;
    logic        err_q, err_d;
    logic        access, is_wr, stall, done, limit;

    assign access         = (state_q == S_FETCH) || (state_q == S_DATA && !decode_q);
    assign is_wr          = state_q == S_DATA && !decode_q && data_write;
    assign stall          = access && bus_waitrequest;
    assign done           = access && !bus_waitrequest;
    assign bus_read       = access && !is_wr;
    assign bus_write      = is_wr;
    assign bus_writedata  = is_wr ? data_writedata : '0;
    assign bus_byteenable = BYTEENABLE_ALL;
    assign bus_address    = state_q == S_FETCH ? (instr_address & WORD_MASK) :
                            state_q == S_DATA  ? (data_address & WORD_MASK) : '0;
    assign cpu_clk_enable = state_q == S_COMMIT;
    assign instr_readdata = instr_q;
    assign data_readdata  = dread_q;
    assign bus_error      = err_q;

    mips_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (!stall),
        .count_en_i (stall),
        .limit_o    (limit)
    );

    // decode_q marks the idle decode cycle spent in DATA before any data strobe
    always_comb begin
        state_d  = state_q;
        decode_d = 1'b0;
        instr_d  = instr_q;
        dread_d  = dread_q;
        err_d    = err_q;
        if (limit) begin
            state_d = S_HALT;
            err_d   = 1'b1;
        end else if (state_q == S_IDLE) begin
            state_d = S_FETCH;
        end else if (state_q == S_FETCH && done) begin
            instr_d  = bus_readdata;
            decode_d = data_read || data_write;
            state_d  = (data_read || data_write) ? S_DATA : S_COMMIT;
        end else if (state_q == S_DATA && done) begin
            dread_d = data_write ? dread_q : bus_readdata;
            state_d = S_COMMIT;
        end else if (state_q == S_COMMIT) begin
            state_d = S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            decode_q <= 1'b0;
            instr_q  <= '0;
            dread_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            decode_q <= decode_d;
            instr_q  <= instr_d;
            dread_q  <= dread_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_mips_harvard_bus_bridge.sv
// tb_mips_harvard_bus_bridge: randomized CPU/slave stimulus with a queue scoreboard checked by a negedge monitor.
module tb_mips_harvard_bus_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_address = '0, data_address = '0, data_writedata = '0;
    logic        data_read = 1'b0, data_write = 1'b0;
    logic [31:0] instr_readdata, data_readdata, bus_address, bus_writedata;
    logic        cpu_clk_enable, bus_read, bus_write, bus_error;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest = 1'b0;
    logic [31:0] bus_readdata = '0;

    mips_harvard_bus_bridge #(.MAX_WAIT(255)) dut (
        .clk(clk), .reset(reset),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_readdata(data_readdata),
        .cpu_clk_enable(cpu_clk_enable), .bus_address(bus_address),
        .bus_read(bus_read), .bus_write(bus_write), .bus_writedata(bus_writedata),
        .bus_byteenable(bus_byteenable), .bus_waitrequest(bus_waitrequest),
        .bus_readdata(bus_readdata), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    typedef struct { logic w; logic [31:0] addr; logic [31:0] wdata; } bus_t;
    typedef struct { logic [31:0] instr; logic [31:0] dread; } cmt_t;
    typedef struct { int waits; logic [31:0] rdata; } slv_t;
    bus_t exp_bus[$];
    cmt_t exp_cmt[$];
    slv_t slv_q[$];
    logic [31:0] model_dread = '0;
    bit stall = 1'b0;
    int checks = 0, passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Slave: serves queued transactions with a programmed number of wait cycles each.
    initial begin
        bit active;
        int wleft;
        logic [31:0] rd;
        slv_t e;
        active = 1'b0;
        wleft = 0;
        rd = '0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) active = 1'b0;
            else begin
                if (active) begin
                    if (wleft == 0) active = 1'b0;
                    else wleft--;
                end
                if (!active && !stall && (bus_read || bus_write) && slv_q.size() > 0) begin
                    e = slv_q.pop_front();
                    active = 1'b1;
                    wleft = e.waits;
                    rd = e.rdata;
                end
            end
            bus_waitrequest = stall || (active && wleft > 0) || (!active && (bus_read || bus_write));
            bus_readdata = active ? rd : $urandom;
        end
    end

    // Monitor: protocol rules, stability under wait, and scoreboard pops on completions/commits.
    logic        prev_v = 1'b0, prev_r = 1'b0, prev_w = 1'b0;
    logic [31:0] prev_addr = '0, prev_wd = '0;
    always @(negedge clk) begin
        bus_t b;
        cmt_t c;
        if (!reset) begin
            if (bus_read || bus_write) check("rw_exclusive", {31'b0, bus_read && bus_write}, 32'd0);
            if (prev_v && !bus_error) begin
                check("stable_addr", bus_address, prev_addr);
                check("stable_strobes", {30'b0, bus_read, bus_write}, {30'b0, prev_r, prev_w});
                check("stable_wdata", bus_writedata, prev_wd);
            end
            if ((bus_read || bus_write) && !bus_waitrequest) begin
                if (exp_bus.size() == 0) check("unexpected_txn", 32'd1, 32'd0);
                else begin
                    b = exp_bus.pop_front();
                    check("txn_write", {31'b0, bus_write}, {31'b0, b.w});
                    check("txn_addr", bus_address, b.addr);
                    check("txn_byteenable", {28'b0, bus_byteenable}, 32'hF);
                    if (b.w) check("txn_wdata", bus_writedata, b.wdata);
                end
            end
            if (cpu_clk_enable) begin
                if (exp_cmt.size() == 0) check("unexpected_commit", 32'd1, 32'd0);
                else begin
                    c = exp_cmt.pop_front();
                    check("commit_instr", instr_readdata, c.instr);
                    check("commit_dread", data_readdata, c.dread);
                end
            end
        end
        prev_v    = !reset && (bus_read || bus_write) && bus_waitrequest;
        prev_r    = bus_read;
        prev_w    = bus_write;
        prev_addr = bus_address;
        prev_wd   = bus_writedata;
    end

    // kind: 0 alu, 1 load, 2 store, 3 load+store (write wins). Called in the first FETCH cycle.
    task automatic run(input int kind, input logic [31:0] iaddr, input logic [31:0] daddr,
                       input logic [31:0] wd, input int fw, input int dw,
                       input logic [31:0] ird, input logic [31:0] drd);
        int n;
        bit mem;
        mem = kind != 0;
        instr_address  = iaddr;
        data_address   = daddr;
        data_writedata = wd;
        data_read      = kind == 1 || kind == 3;
        data_write     = kind >= 2;
        exp_bus.push_back('{1'b0, iaddr & 32'hFFFF_FFFC, 32'h0});
        slv_q.push_back('{fw, ird});
        if (mem) begin
            exp_bus.push_back('{kind >= 2, daddr & 32'hFFFF_FFFC, wd});
            slv_q.push_back('{dw, drd});
            if (kind == 1) model_dread = drd;
        end
        exp_cmt.push_back('{ird, model_dread});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_clk_enable && n < 600);
        check("latency", n, mem ? 4 + fw + dw : 2 + fw);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        data_read = 1'b0;
        data_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus_read", {31'b0, bus_read}, 32'd0);
        check("rst_bus_write", {31'b0, bus_write}, 32'd0);
        check("rst_cpu_clk_enable", {31'b0, cpu_clk_enable}, 32'd0);
        check("rst_bus_error", {31'b0, bus_error}, 32'd0);
        check("rst_instr_readdata", instr_readdata, 32'd0);
        check("rst_data_readdata", data_readdata, 32'd0);
        check("rst_bus_address", bus_address, 32'd0);
        model_dread = '0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("fresh_fetch", {31'b0, bus_read}, 32'd1);
    endtask

    initial begin
        int n;
        int pulses;
        do_reset();
        run(0, 32'h0000_0004, $urandom, $urandom, 0, 0, 32'h0000_0020, $urandom);
        run(1, 32'h0000_0008, 32'h0000_1002, $urandom, 0, 3, 32'h8C22_0000, 32'hDEAD_BEEF);
        run(2, 32'h0000_000C, 32'h0000_2001, 32'h1234_5678, 1, 0, 32'hAC23_0000, $urandom);
        run(3, 32'h0000_0010, 32'h0000_3007, 32'hCAFE_F00D, 0, 2, $urandom, $urandom);
        run(0, 32'h0000_0014, $urandom, $urandom, 2, 0, $urandom, $urandom);
        for (int i = 0; i < 40; i++)
            run($urandom_range(0, 3), $urandom, $urandom, $urandom,
                ($urandom_range(0, 3) == 0) ? $urandom_range(4, 12) : $urandom_range(0, 2),
                $urandom_range(0, 5), $urandom, $urandom);

        // Timeout: slave never releases waitrequest.
        stall = 1'b1;
        instr_address = $urandom;
        data_read = 1'b0;
        data_write = 1'b0;
        n = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_error) break;
            if (bus_read) n++;
        end
        check("timeout_wait_cycles", n, 32'd255);
        check("halt_bus_error", {31'b0, bus_error}, 32'd1);
        check("halt_strobes", {30'b0, bus_read, bus_write}, 32'd0);
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpu_clk_enable || bus_read || bus_write) pulses++;
        end
        check("halt_quiet", pulses, 32'd0);
        @(posedge clk);
        #1;

        // Reset during a stalled fetch, then a fresh fetch must follow.
        do_reset();
        stall = 1'b1;
        instr_address = 32'h0000_0100;
        repeat (5) @(negedge clk);
        check("stalled_fetch_read", {31'b0, bus_read}, 32'd1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_drops_strobes", {30'b0, bus_read, bus_write}, 32'd0);
        do_reset();
        run(0, 32'h0000_0104, $urandom, $urandom, 0, 0, 32'h0000_0000, $urandom);
        run(1, 32'h0000_0108, 32'h0000_4000, $urandom, 1, 1, $urandom, 32'h5555_AAAA);

        check("bus_queue_drained", exp_bus.size(), 32'd0);
        check("commit_queue_drained", exp_cmt.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, checks);
        $fatal(1);
    end
endmodule

// File: doc/mips_harvard_bus_bridge.md
MIPS_HARVARD_BUS_BRIDGE -- requirements
Module: mips_harvard_bus_bridge

Interface
REQ-001 Parameter: MAX_WAIT, 255, maximum consecutive waitrequest-high cycles tolerated per bus transaction.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 instr_address  input  32  CPU fetch address.
REQ-005 instr_readdata  output  32  latched instruction word presented to CPU.
REQ-006 data_address  input  32  CPU data address.
REQ-007 data_read  input  1  CPU data read request.
REQ-008 data_write  input  1  CPU data write request.
REQ-009 data_writedata  input  32  CPU store data.
REQ-010 data_readdata  output  32  latched load data presented to CPU.
REQ-011 cpu_clk_enable  output  1  one-cycle CPU advance strobe.
REQ-012 bus_address  output  32  shared-bus word address.
REQ-013 bus_read  output  1  bus read strobe.
REQ-014 bus_write  output  1  bus write strobe.
REQ-015 bus_writedata  output  32  bus store data.
REQ-016 bus_byteenable  output  4  byte lanes; constant 4'b1111.
REQ-017 bus_waitrequest  input  1  slave stall; transfer completes in a cycle where strobe is high and waitrequest is low.
REQ-018 bus_readdata  input  32  bus read data, valid in the completing cycle.
REQ-019 bus_error  output  1  sticky timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, FETCH, DATA, COMMIT, HALT.
REQ-021 IDLE -> FETCH unconditionally on the first cycle after reset deasserts.
REQ-022 FETCH: bus_read=1, bus_address={instr_address[31:2],2'b00}; on completion, latch bus_readdata into instr_readdata.
REQ-023 On FETCH completion, next state SHALL be DATA if the CPU asserts data_read or data_write in that cycle (decode from newly latched instruction, evaluated the following cycle), otherwise COMMIT; one decode cycle SHALL be inserted in state DATA before strobes assert.
REQ-024 DATA: bus_address={data_address[31:2],2'b00}; data_write=1 drives bus_write=1 and bus_writedata=data_writedata; else bus_read=1; on read completion, latch bus_readdata into data_readdata.
REQ-025 Simultaneous data_read and data_write SHALL perform the write only.
REQ-026 bus_read and bus_write SHALL never be high together.
REQ-027 Strobes, address and writedata SHALL remain stable while bus_waitrequest is high.
REQ-028 COMMIT: cpu_clk_enable=1 for exactly one cycle, then FETCH; cpu_clk_enable=0 in all other states.
REQ-029 instr_readdata and data_readdata SHALL hold their values through COMMIT.
REQ-030 Latency with zero wait states: 2 cycles per non-memory instruction (FETCH, COMMIT), 4 per load/store (FETCH, DATA decode, DATA access, COMMIT).
REQ-031 A wait counter SHALL count consecutive waitrequest-high cycles in FETCH/DATA; reaching MAX_WAIT sets bus_error=1, drops strobes, and enters HALT.
REQ-032 HALT: all strobes 0, cpu_clk_enable 0; exit only via reset.
REQ-033 Wait counter SHALL clear on every transfer completion and state change.

Reset
REQ-034 During reset: state IDLE, bus_read=0, bus_write=0, cpu_clk_enable=0, bus_error=0, instr_readdata=0, data_readdata=0, bus_address=0, wait counter=0.
REQ-035 Reset asserted mid-transaction SHALL drop strobes on the next edge regardless of bus_waitrequest.

Structure
REQ-036 A shared package mips_bus_pkg SHALL hold the state enum, BYTEENABLE_ALL=4'b1111, and the word-alignment mask.
REQ-037 One sub-module, mips_wait_counter (clear, count-enable, limit-reached), SHALL implement the timeout counter.

Verification
REQ-038 Zero-wait ALU instruction at address 0x00000004 -> bus_read with address 0x4 for one cycle, cpu_clk_enable pulses on the 2nd cycle after FETCH entry.
REQ-039 Load: data_address=0x00001002, slave returns 0xDEADBEEF after 3 wait cycles -> bus_address=0x00001000, stable for 4 cycles, data_readdata=0xDEADBEEF during COMMIT.
REQ-040 Store: data_write=1, data_writedata=0x12345678 -> one bus_write, byteenable 4'b1111, bus_read never concurrent.
REQ-041 Both data_read and data_write high -> only bus_write observed.
REQ-042 waitrequest held high for 255 cycles -> bus_error=1, strobes 0, no further cpu_clk_enable until reset.
REQ-043 Reset asserted during a waited FETCH -> strobes 0 after next edge, IDLE, then fresh FETCH.
